// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and status bundle for alu_arbiter.
// Optional macro ALU_ARB_FLAGS_EN adds per-requester setflags inputs and
// the architectural flags_nzcv output.
interface alu_arbiter_if #(
   parameter int CNT_W = 16
);
   logic              req0_valid;
   logic              req0_ready;
   logic [2:0]        req0_cntrl;
   logic [63:0]       req0_a;
   logic [63:0]       req0_b;
   logic              req1_valid;
   logic              req1_ready;
   logic [2:0]        req1_cntrl;
   logic [63:0]       req1_a;
   logic [63:0]       req1_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [63:0]       rsp_result;
   logic              rsp_negative;
   logic              rsp_zero;
   logic              rsp_overflow;
   logic              rsp_carry_out;
   logic              rsp_err;
   logic [CNT_W-1:0]  op_count;
`ifdef ALU_ARB_FLAGS_EN
   logic              req0_setflags;
   logic              req1_setflags;
   logic [3:0]        flags_nzcv;
`endif

   // Requesters and response consumer
   modport master (
      output req0_valid, req0_cntrl, req0_a, req0_b,
      output req1_valid, req1_cntrl, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_result,
      input  rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_err,
`ifdef ALU_ARB_FLAGS_EN
      output req0_setflags, req1_setflags,
      input  flags_nzcv,
`endif
      output rsp_ready,
      input  op_count
   );

   // Arbiter side
   modport slave (
      input  req0_valid, req0_cntrl, req0_a, req0_b,
      input  req1_valid, req1_cntrl, req1_a, req1_b,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_result,
      output rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_err,
`ifdef ALU_ARB_FLAGS_EN
      input  req0_setflags, req1_setflags,
      output flags_nzcv,
`endif
      input  rsp_ready,
      output op_count
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one 64-bit ALU; the winner's result and
// flags land in a single-entry response register tagged with its ID.
// Optional macro ALU_ARB_FLAGS_EN adds a setflags-controlled NZCV register.
module alu_arbiter #(
   parameter bit FAIR  = 1'b1,
   parameter int CNT_W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   alu_arbiter_if.slave bus
);
   logic              rsp_valid_reg;
   logic              rsp_id_reg;
   logic [63:0]       rsp_result_reg;
   logic              rsp_negative_reg;
   logic              rsp_zero_reg;
   logic              rsp_overflow_reg;
   logic              rsp_carry_out_reg;
   logic              rsp_err_reg;
   logic [CNT_W-1:0]  op_count_reg;
   logic              last_grant_reg;

   logic [1:0]  req_valid;
   logic [1:0]  grant;
   logic [1:0]  ready;
   logic        slot_free;
   logic        accept;
   logic        win_id;
   logic [2:0]  alu_cntrl;
   logic [63:0] alu_a;
   logic [63:0] alu_b;

   logic [63:0] alu_result;
   logic [64:0] alu_sum;
   logic        alu_negative;
   logic        alu_zero;
   logic        alu_overflow;
   logic        alu_carry_out;
   logic        alu_err;

   assign req_valid = {bus.req1_valid, bus.req0_valid};
   assign slot_free = ~rsp_valid_reg | bus.rsp_ready;

   // Single winner: req1 only when alone, or when both ask and it is its turn
   always_comb begin
      grant    = 2'b00;
      grant[1] = req_valid[1] & (~req_valid[0] | (FAIR & ~last_grant_reg));
      grant[0] = req_valid[0] & ~grant[1];
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ready
         assign ready[gi] = grant[gi] & slot_free;
      end
   endgenerate

   assign bus.req0_ready = ready[0];
   assign bus.req1_ready = ready[1];
   assign accept         = |ready;
   assign win_id         = grant[1];
   assign alu_cntrl      = win_id ? bus.req1_cntrl : bus.req0_cntrl;
   assign alu_a          = win_id ? bus.req1_a     : bus.req0_a;
   assign alu_b          = win_id ? bus.req1_b     : bus.req0_b;

   // Shared ALU; V and C are only meaningful for add/sub, illegal ops yield all zeros
   always_comb begin
      alu_result    = 64'd0;
      alu_sum       = 65'd0;
      alu_overflow  = 1'b0;
      alu_carry_out = 1'b0;
      alu_err       = 1'b0;
      case (alu_cntrl)
         3'b000: alu_result = alu_b;
         3'b010: begin
            alu_sum       = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result    = alu_sum[63:0];
            alu_carry_out = alu_sum[64];
            alu_overflow  = (alu_a[63] == alu_b[63]) && (alu_result[63] != alu_a[63]);
         end
         3'b011: begin
            // A + ~B + 1, so the carry out is the no-borrow indication
            alu_sum       = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
            alu_result    = alu_sum[63:0];
            alu_carry_out = alu_sum[64];
            alu_overflow  = (alu_a[63] != alu_b[63]) && (alu_result[63] != alu_a[63]);
         end
         3'b100:  alu_result = alu_a & alu_b;
         3'b101:  alu_result = alu_a | alu_b;
         3'b110:  alu_result = alu_a ^ alu_b;
         default: alu_err    = 1'b1;
      endcase
      alu_negative = ~alu_err & alu_result[63];
      alu_zero     = ~alu_err & (alu_result == 64'd0);
   end

   // Response register, round-robin pointer and saturating consumed-op counter
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rsp_valid_reg     <= 1'b0;
         rsp_id_reg        <= 1'b0;
         rsp_result_reg    <= 64'd0;
         rsp_negative_reg  <= 1'b0;
         rsp_zero_reg      <= 1'b0;
         rsp_overflow_reg  <= 1'b0;
         rsp_carry_out_reg <= 1'b0;
         rsp_err_reg       <= 1'b0;
         op_count_reg      <= '0;
         last_grant_reg    <= 1'b1;
      end else begin
         if (accept) begin
            rsp_valid_reg     <= 1'b1;
            rsp_id_reg        <= win_id;
            rsp_result_reg    <= alu_result;
            rsp_negative_reg  <= alu_negative;
            rsp_zero_reg      <= alu_zero;
            rsp_overflow_reg  <= alu_overflow;
            rsp_carry_out_reg <= alu_carry_out;
            rsp_err_reg       <= alu_err;
            last_grant_reg    <= win_id;
         end else if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
         end
         if (rsp_valid_reg && bus.rsp_ready && (op_count_reg != '1)) begin
            op_count_reg <= op_count_reg + CNT_W'(1);
         end
      end
   end

   assign bus.rsp_valid     = rsp_valid_reg;
   assign bus.rsp_id        = rsp_id_reg;
   assign bus.rsp_result    = rsp_result_reg;
   assign bus.rsp_negative  = rsp_negative_reg;
   assign bus.rsp_zero      = rsp_zero_reg;
   assign bus.rsp_overflow  = rsp_overflow_reg;
   assign bus.rsp_carry_out = rsp_carry_out_reg;
   assign bus.rsp_err       = rsp_err_reg;
   assign bus.op_count      = op_count_reg;

`ifdef ALU_ARB_FLAGS_EN
   logic [3:0] flags_nzcv_reg;
   logic       win_setflags;

   assign win_setflags = win_id ? bus.req1_setflags : bus.req0_setflags;

   // Architectural flags follow only legal, flag-setting accepted ops
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         flags_nzcv_reg <= 4'd0;
      end else if (accept && win_setflags && !alu_err) begin
         flags_nzcv_reg <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
      end
   end

   assign bus.flags_nzcv = flags_nzcv_reg;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, ALU results/flags,
// backpressure, reset and (with ALU_ARB_FLAGS_EN) the NZCV register.
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   compared = 0;
   int   mismatched = 0;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

   always #5 clk = ~clk;

   alu_arbiter_if #(.CNT_W(16)) bus ();

   alu_arbiter #(.FAIR(1'b1), .CNT_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_rsp(input string tag, input logic id, input logic [63:0] res,
                          input logic n, input logic z, input logic v, input logic c,
                          input logic err);
      $display("txn %s: id=%0d result=%h nzvc=%b%b%b%b err=%b", tag, bus.rsp_id,
               bus.rsp_result, bus.rsp_negative, bus.rsp_zero, bus.rsp_overflow,
               bus.rsp_carry_out, bus.rsp_err);
      chk({tag, ".valid"}, 64'(bus.rsp_valid), 64'd1);
      chk({tag, ".id"}, 64'(bus.rsp_id), 64'(id));
      chk({tag, ".result"}, bus.rsp_result, res);
      chk({tag, ".nzvc"}, 64'({bus.rsp_negative, bus.rsp_zero, bus.rsp_overflow,
                               bus.rsp_carry_out}), 64'({n, z, v, c}));
      chk({tag, ".err"}, 64'(bus.rsp_err), 64'(err));
   endtask

   task automatic chk_ready(input string tag, input logic r0, input logic r1);
      chk({tag, ".ready"}, 64'({bus.req1_ready, bus.req0_ready}), 64'({r1, r0}));
   endtask

   task automatic drive0(input logic v, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b);
      bus.req0_valid = v;
      bus.req0_cntrl = op;
      bus.req0_a     = a;
      bus.req0_b     = b;
   endtask

   task automatic drive1(input logic v, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b);
      bus.req1_valid = v;
      bus.req1_cntrl = op;
      bus.req1_a     = a;
      bus.req1_b     = b;
   endtask

   initial begin
      drive0(1'b0, 3'b000, 64'd0, 64'd0);
      drive1(1'b0, 3'b000, 64'd0, 64'd0);
      bus.rsp_ready = 1'b0;
`ifdef ALU_ARB_FLAGS_EN
      bus.req0_setflags = 1'b0;
      bus.req1_setflags = 1'b0;
`endif
      // Reset state
      tick();
      tick();
      chk("rst.valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst.result", bus.rsp_result, 64'd0);
      chk("rst.id_err", 64'({bus.rsp_id, bus.rsp_err}), 64'd0);
      chk("rst.op_count", 64'(bus.op_count), 64'd0);
`ifdef ALU_ARB_FLAGS_EN
      chk("rst.nzcv", 64'(bus.flags_nzcv), 64'd0);
`endif

      // 1 + 1 from req0
      reset_n = 1'b1;
      bus.rsp_ready = 1'b1;
      drive0(1'b1, 3'b010, 64'd1, 64'd1);
      settle();
      chk_ready("add1", 1'b1, 1'b0);
      tick();
      chk_rsp("add1", 1'b0, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("add1.op_count", 64'(bus.op_count), 64'd0);
      bus.req0_valid = 1'b0;
      tick();
      chk("drain1.valid", 64'(bus.rsp_valid), 64'd0);
      chk("drain1.op_count", 64'(bus.op_count), 64'd1);

      // Both valid: last winner was req0, so req1 goes first, then alternate
      drive0(1'b1, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      drive1(1'b1, 3'b011, 64'd1, 64'd1);
      settle();
      chk_ready("rr0", 1'b0, 1'b1);
      tick();
      chk_rsp("rr_sub", 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk_ready("rr1", 1'b1, 1'b0);
      tick();
      chk_rsp("rr_add", 1'b0, MINV, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_ready("rr2", 1'b0, 1'b1);
      tick();
      chk_rsp("rr_sub2", 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_rsp("rr_add2", 1'b0, MINV, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("rr.op_count", 64'(bus.op_count), 64'd4);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      tick();
      chk("drain2.valid", 64'(bus.rsp_valid), 64'd0);
      chk("drain2.op_count", 64'(bus.op_count), 64'd5);

      // Backpressure: response held for three cycles
      bus.rsp_ready = 1'b0;
      drive0(1'b1, 3'b101, 64'hF0, 64'h0F);
      settle();
      chk_ready("or", 1'b1, 1'b0);
      tick();
      chk_rsp("or", 1'b0, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive0(1'b1, 3'b100, 64'hFF, 64'h0F);
      drive1(1'b1, 3'b100, ONES, ONES);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk_ready("hold", 1'b0, 1'b0);
         tick();
         chk_rsp("hold", 1'b0, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk("hold.op_count", 64'(bus.op_count), 64'd5);
      bus.rsp_ready = 1'b1;
      settle();
      chk_ready("release", 1'b0, 1'b1);
      tick();
      chk_rsp("and_ones", 1'b1, ONES, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("release.op_count", 64'(bus.op_count), 64'd6);
      drive1(1'b1, 3'b111, 64'd5, 64'd3);
      chk_ready("and0f", 1'b1, 1'b0);
      tick();
      chk_rsp("and0f", 1'b0, 64'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_ready("illegal", 1'b0, 1'b1);
      tick();
      chk_rsp("illegal", 1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("illegal.op_count", 64'(bus.op_count), 64'd8);

      // Reset wins over a simultaneous handshake
      reset_n = 1'b0;
      tick();
      chk("rst2.valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst2.op_count", 64'(bus.op_count), 64'd0);
      chk("rst2.result", bus.rsp_result, 64'd0);
      chk("rst2.err", 64'(bus.rsp_err), 64'd0);
      reset_n = 1'b1;
      settle();
      chk_ready("rst2.first", 1'b1, 1'b0);
      tick();
      chk_rsp("rst2.first", 1'b0, 64'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Flag-setting sub, then a non-setting xor
      bus.req1_valid = 1'b0;
      drive0(1'b1, 3'b011, 64'd1, MINV);
`ifdef ALU_ARB_FLAGS_EN
      bus.req0_setflags = 1'b1;
`endif
      tick();
      chk_rsp("sub_min", 1'b0, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef ALU_ARB_FLAGS_EN
      chk("sub_min.nzcv", 64'(bus.flags_nzcv), 64'b1010);
      bus.req0_setflags = 1'b0;
`endif
      drive0(1'b1, 3'b110, 64'd3, 64'd5);
      tick();
      chk_rsp("xor", 1'b0, 64'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_ARB_FLAGS_EN
      chk("xor.nzcv", 64'(bus.flags_nzcv), 64'b1010);
`endif
      bus.req0_valid = 1'b0;
      tick();
      chk("drain3.valid", 64'(bus.rsp_valid), 64'd0);
      chk("drain3.op_count", 64'(bus.op_count), 64'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
